mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH, default 2**16: number of 32-bit words in the attached RAM.
REQ-002 Parameter DATA_WIDTH, default 32: RAM word width; only 32 is supported.
REQ-003 Clock is i_clk; reset is i_rst_n, asynchronous and active-low.
REQ-004 i_clk  in  1  single clock for all logic.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req_valid  in  1  core request valid.
REQ-007 o_req_ready  out  1  request accepted when valid and ready are both high.
REQ-008 i_req_we  in  1  1 = store, 0 = load.
REQ-009 i_req_funct3  in  3  RISC-V width code: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
REQ-010 i_req_addr  in  32  byte address.
REQ-011 i_req_wdata  in  32  store data, taken from the low bits.
REQ-012 o_rsp_valid  out  1  one-cycle response pulse.
REQ-013 o_rdata  out  32  load result; 0 for stores and errors.
REQ-014 o_err  out  1  misaligned or illegal funct3; valid with o_rsp_valid.
REQ-015 o_ram_en  out  1  RAM port enable.
REQ-016 o_ram_we  out  1  RAM write enable.
REQ-017 o_ram_addr  out  $clog2(DEPTH)  RAM word address.
REQ-018 o_ram_wdata  out  32  RAM write word.
REQ-019 i_ram_rdata  in  32  RAM read data, valid one cycle after the enabled read cycle.

Function
REQ-020 FSM states SHALL be IDLE, RD, RD_WAIT, WR, RESP; o_req_ready SHALL be 1 only in IDLE.
REQ-021 On acceptance, the unit SHALL register we, funct3, word address (i_req_addr[$clog2(DEPTH)+1:2]), byte offset (i_req_addr[1:0]) and wdata; upper address bits are ignored, so addresses wrap.
REQ-022 Error cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 011, 110 or 111. On error, IDLE->RESP with o_err=1 and no RAM enable.
REQ-023 Load: IDLE(N)->RD(N+1, en=1, we=0)->RD_WAIT(N+2, capture i_ram_rdata)->RESP(N+3).
REQ-024 SW: IDLE(N)->WR(N+1, en=1, we=1, full word)->RESP(N+2).
REQ-025 SB/SH (read-modify-write): IDLE(N)->RD(N+1)->RD_WAIT(N+2, merge lanes)->WR(N+3, merged word)->RESP(N+4).
REQ-026 Byte lane k SHALL occupy bits [8k+7:8k] (little-endian); halfword at offset 2 SHALL occupy [31:16].
REQ-027 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL return the word unmodified.
REQ-028 In RESP, o_rsp_valid=1 for exactly one cycle, then return to IDLE; a new request can be accepted in the cycle after RESP.
REQ-029 o_ram_en/o_ram_we SHALL be 0 in IDLE, RD_WAIT and RESP; o_ram_* SHALL be decoded from registered state only, with no combinational path from i_req_*.
REQ-030 i_req_* SHALL be ignored outside IDLE; requests held valid across busy cycles SHALL be accepted once, in IDLE.

Reset
REQ-031 While i_rst_n=0: state=IDLE; o_rsp_valid, o_err, o_rdata, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata all 0; o_req_ready=1 after release.
REQ-032 A reset mid-operation SHALL abort it with no subsequent RAM write and no response.

Structure
REQ-033 Package mem_pkg SHALL hold the FSM state enum and the funct3 width constants.
REQ-034 Combinational sub-module mem_byte_lane SHALL perform load extraction/extension and store lane merging.

Verification (RAM model with 1-cycle read latency; word 0x100 preloaded 0x8899AABB)
REQ-035 LB 0x103 -> o_rdata 0xFFFFFF88 at N+3; LBU 0x103 -> 0x00000088.
REQ-036 SB 0x101, wdata 0x000000CC -> WR at N+3 with o_ram_wdata 0x8899CCBB, RESP at N+4; a following LW 0x100 -> 0x8899CCBB.
REQ-037 LW 0x102 -> o_err=1 and o_rsp_valid at N+1; o_ram_en never asserts.
REQ-038 Two SW requests with i_req_valid held high -> second accepted at N+3; exactly two RAM writes occur.
REQ-039 SH 0x102 with i_rst_n asserted during RD_WAIT -> o_ram_en=0 immediately; no write and no response; after release, o_req_ready=1 and LHU 0x102 returns 0x00008899.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : FSM states and RISC-V load/store width codes for the unit.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Misaligned halfword/word accesses and unused width codes are rejected.
  function automatic logic req_err(input logic [2:0] funct3, input logic [1:0] offset);
    logic err;
    case (funct3)
      F3_B, F3_BU: err = 1'b0;
      F3_H, F3_HU: err = offset[0];
      F3_W:        err = (offset != 2'b00);
      default:     err = 1'b1;
    endcase
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_byte_lane : load lane extraction/extension and store lane merging.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase

    merged = rdata;
    case (funct3[1:0])
      SZ_BYTE: merged[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit : byte/half/word load-store bridge to a 1-cycle RAM.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH      = 2**16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [2:0]               i_req_funct3,
  input  logic [31:0]              i_req_addr,
  input  logic [DATA_WIDTH-1:0]    i_req_wdata,
  output logic                     o_rsp_valid,
  output logic [DATA_WIDTH-1:0]    o_rdata,
  output logic                     o_err,
  output logic                     o_ram_en,
  output logic                     o_ram_we,
  output logic [$clog2(DEPTH)-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0]    o_ram_wdata,
  input  logic [DATA_WIDTH-1:0]    i_ram_rdata
);

  localparam int AW = $clog2(DEPTH);

  state_t            state, next_state;
  logic              accept;
  logic              new_err;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [AW-1:0]     req_addr;
  logic [1:0]        req_off;
  logic [31:0]       req_wdata;
  logic [31:0]       ram_word;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [31:0]       lane_load;
  logic [31:0]       lane_merged;
  logic              unused_addr_bits;

  assign unused_addr_bits = &{1'b0, i_req_addr[31:AW+2]};

  assign accept  = i_req_valid && (state == ST_IDLE);
  assign new_err = req_err(i_req_funct3, i_req_addr[1:0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (new_err)                                      next_state = ST_RESP;
          else if (i_req_we && i_req_funct3[1:0] == SZ_WORD) next_state = ST_WR;
          else                                              next_state = ST_RD;
        end
      end
      ST_RD:      next_state = ST_RD_WAIT;
      ST_RD_WAIT: next_state = req_we ? ST_WR : ST_RESP;
      ST_WR:      next_state = ST_RESP;
      ST_RESP:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // ram_word carries the full store word for SW and the merged word for SB/SH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_we     <= 1'b0;
      req_funct3 <= 3'b000;
      req_addr   <= '0;
      req_off    <= 2'b00;
      req_wdata  <= 32'h0;
      ram_word   <= 32'h0;
      rsp_data   <= 32'h0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      req_we     <= i_req_we;
      req_funct3 <= i_req_funct3;
      req_addr   <= i_req_addr[AW+1:2];
      req_off    <= i_req_addr[1:0];
      req_wdata  <= i_req_wdata;
      ram_word   <= i_req_wdata;
      rsp_data   <= 32'h0;
      rsp_err    <= new_err;
    end else if (state == ST_RD_WAIT) begin
      if (req_we) ram_word <= lane_merged;
      else        rsp_data <= lane_load;
    end
  end

  mem_byte_lane u_lane (
    .funct3    (req_funct3),
    .offset    (req_off),
    .rdata     (i_ram_rdata),
    .wdata     (req_wdata),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  assign o_req_ready = (state == ST_IDLE);
  assign o_rsp_valid = (state == ST_RESP);
  assign o_err       = (state == ST_RESP) && rsp_err;
  assign o_rdata     = (state == ST_RESP) ? rsp_data : 32'h0;
  assign o_ram_en    = (state == ST_RD) || (state == ST_WR);
  assign o_ram_we    = (state == ST_WR);
  assign o_ram_addr  = req_addr;
  assign o_ram_wdata = ram_word;

endmodule
`default_nettype wire
